// File: rtl/jtag_scan_pkg.sv
// ---------------------------------------------------------------------------
// jtag_scan_pkg
// Shared types and helpers for the JTAG data-register scan master.
//   scan_state_e : scan FSM state encoding
//   cnt_width()  : shift counter width for a given chain length (at least 1)
// ---------------------------------------------------------------------------
package jtag_scan_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        UPDATE  = 3'd3,
        RESP    = 3'd4
    } scan_state_e;

    // Counter width able to hold 0..len-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned len);
        if (len <= 1) begin
            return 1;
        end
        return $clog2(len);
    endfunction

endpackage : jtag_scan_pkg

// File: rtl/jtag_dr_scan_master.sv
// ---------------------------------------------------------------------------
// jtag_dr_scan_master
// Turns one parallel request word into a full DR scan of a single
// capture/shift/update chain (optional capture, CHAIN_LEN shifts, one update)
// and returns the word shifted out of the chain on a response channel.
//
// Ports
//   clock, reset        : sole clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_wdata           : word to load, bit k ends up in chain stage k
//   req_capture         : issue a capture strobe before shifting
//   resp_valid/ready    : response handshake
//   resp_rdata          : word shifted out, bit k = stage k before shifting
//   resp_err            : capture-signature error (LSB of captured word not 1)
//   chain_capture/shift/update : one-hot strobes to the chain
//   chain_data          : serial data into the chain's far end
//   chain_out_data      : serial data from the chain's stage 0
//
// Build option
//   JTAG_SCAN_CAPTURE_CHECK_EN : enables resp_err signature check and a
//   simulation-only strobe-exclusivity assertion. When undefined resp_err is 0.
// ---------------------------------------------------------------------------
module jtag_dr_scan_master
    import jtag_scan_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CHAIN_LEN-1:0] req_wdata,
    input  logic                 req_capture,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [CHAIN_LEN-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 chain_capture,
    output logic                 chain_shift,
    output logic                 chain_update,
    output logic                 chain_data,
    input  logic                 chain_out_data
);

    localparam int unsigned CNT_W = cnt_width(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    scan_state_e          state_q;
    logic [CHAIN_LEN-1:0] tx_q;
    logic [CHAIN_LEN-1:0] tx_d;
    logic [CHAIN_LEN-1:0] rx_q;
    logic [CHAIN_LEN-1:0] rx_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic [CHAIN_LEN-1:0] resp_rdata_q;
    logic                 chain_capture_q;
    logic                 chain_shift_q;
    logic                 chain_update_q;
    logic                 chain_data_q;

    // Shift-register next values: tx drains LSB first, rx fills from the MSB
    // so that after CHAIN_LEN shifts rx[k] holds the old contents of stage k.
    always_comb begin
        tx_d = tx_q >> 1;
        rx_d = rx_q >> 1;
        rx_d[CHAIN_LEN-1] = chain_out_data;
    end

`ifdef JTAG_SCAN_CAPTURE_CHECK_EN
    logic cap_q;
    logic resp_err_q;
`endif

    // Scan FSM with registered strobes, serial data and response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            tx_q            <= '0;
            rx_q            <= '0;
            cnt_q           <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            chain_capture_q <= 1'b0;
            chain_shift_q   <= 1'b0;
            chain_update_q  <= 1'b0;
            chain_data_q    <= 1'b0;
`ifdef JTAG_SCAN_CAPTURE_CHECK_EN
            cap_q           <= 1'b0;
            resp_err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rx_q        <= '0;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
`ifdef JTAG_SCAN_CAPTURE_CHECK_EN
                        cap_q       <= req_capture;
`endif
                        if (req_capture) begin
                            tx_q            <= req_wdata;
                            chain_capture_q <= 1'b1;
                            state_q         <= CAPTURE;
                        end else begin
                            // First serial bit is presented with the shift strobe.
                            tx_q          <= req_wdata >> 1;
                            chain_data_q  <= req_wdata[0];
                            chain_shift_q <= 1'b1;
                            state_q       <= SHIFT;
                        end
                    end
                end

                CAPTURE: begin
                    chain_capture_q <= 1'b0;
                    chain_shift_q   <= 1'b1;
                    chain_data_q    <= tx_q[0];
                    tx_q            <= tx_d;
                    state_q         <= SHIFT;
                end

                SHIFT: begin
                    rx_q <= rx_d;
                    if (cnt_q == CNT_LAST) begin
                        chain_shift_q  <= 1'b0;
                        chain_data_q   <= 1'b0;
                        chain_update_q <= 1'b1;
                        state_q        <= UPDATE;
                    end else begin
                        cnt_q        <= cnt_q + CNT_W'(1);
                        chain_data_q <= tx_q[0];
                        tx_q         <= tx_d;
                    end
                end

                UPDATE: begin
                    chain_update_q <= 1'b0;
                    resp_rdata_q   <= rx_q;
                    resp_valid_q   <= 1'b1;
`ifdef JTAG_SCAN_CAPTURE_CHECK_EN
                    resp_err_q     <= cap_q & ~rx_q[0];
`endif
                    state_q        <= RESP;
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign chain_capture = chain_capture_q;
    assign chain_shift   = chain_shift_q;
    assign chain_update  = chain_update_q;
    assign chain_data    = chain_data_q;

`ifdef JTAG_SCAN_CAPTURE_CHECK_EN
    assign resp_err = resp_err_q;

`ifndef SYNTHESIS
    // Chain strobes must be mutually exclusive.
    always @(posedge clock) begin
        if (!reset) begin
            assert ($onehot0({chain_capture_q, chain_shift_q, chain_update_q}))
                else $error("chain strobes overlap");
        end
    end
`endif
`else
    assign resp_err = 1'b0;
`endif

endmodule : jtag_dr_scan_master

// File: tb/tb_jtag_dr_scan_master.sv
// ---------------------------------------------------------------------------
// tb_jtag_dr_scan_master
// Randomised scoreboard bench: a behavioural chain model answers the DUT's
// strobes; expected responses come from a word-level reference of the chain
// contents and are popped by an independent monitor on each handshake.
// ---------------------------------------------------------------------------
module tb_jtag_dr_scan_master;

    localparam int unsigned CHAIN_LEN = 32;
    localparam int unsigned RST_AT    = (CHAIN_LEN < 16) ? CHAIN_LEN : 16;

    typedef logic [CHAIN_LEN-1:0] word_t;

    typedef struct {
        word_t       rdata;
        logic        err;
        int unsigned e0;
        logic        cap;
        word_t       wdata;
    } exp_t;

    logic  clock = 1'b0;
    logic  reset = 1'b1;
    logic  req_valid = 1'b0;
    logic  req_ready;
    word_t req_wdata = '0;
    logic  req_capture = 1'b0;
    logic  resp_valid;
    logic  resp_ready = 1'b0;
    word_t resp_rdata;
    logic  resp_err;
    logic  chain_capture;
    logic  chain_shift;
    logic  chain_update;
    logic  chain_data;
    logic  chain_out_data;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    exp_t  sb[$];
    word_t ref_chain = '0;
    word_t chain_m = '0;
    word_t cap_val = '0;

    int unsigned overlaps = 0;
    int unsigned hold_cnt = 0;
    int unsigned n_sh = 0, n_cap = 0, n_up = 0;
    logic        seen = 1'b0;
    logic        idle_chk = 1'b0;
    int unsigned rise = 0;
    int unsigned unstable = 0;
    word_t       held_rdata = '0;
    logic        held_err = 1'b0;

    jtag_dr_scan_master #(.CHAIN_LEN(CHAIN_LEN)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wdata      (req_wdata),
        .req_capture    (req_capture),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .chain_capture  (chain_capture),
        .chain_shift    (chain_shift),
        .chain_update   (chain_update),
        .chain_data     (chain_data),
        .chain_out_data (chain_out_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Behavioural scan chain: capture loads cap_val, shift moves toward stage 0.
    always @(posedge clock) begin
        if (chain_capture) begin
            chain_m <= cap_val;
        end else if (chain_shift) begin
            chain_m <= (chain_m >> 1) | (word_t'(chain_data) << (CHAIN_LEN - 1));
        end
    end
    assign chain_out_data = chain_m[0];

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic word_t rnd_word();
        word_t r;
        for (int i = 0; i < CHAIN_LEN; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Issue one request; expectation is computed from the word-level chain reference.
    task automatic send(input word_t wd, input logic cap, input word_t cv);
        exp_t e;
        int   b;
        b = 0;
        @(negedge clock);
        while (!req_ready && b < 5000) begin
            @(negedge clock);
            b++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", req_ready, 1);
            return;
        end
        cap_val     = cv;
        req_valid   = 1'b1;
        req_wdata   = wd;
        req_capture = cap;
        e.rdata = cap ? cv : ref_chain;
`ifdef JTAG_SCAN_CAPTURE_CHECK_EN
        e.err = cap & ~e.rdata[0];
`else
        e.err = 1'b0;
`endif
        e.e0    = cyc + 1;
        e.cap   = cap;
        e.wdata = wd;
        sb.push_back(e);
        ref_chain = wd;
        @(posedge clock);
        #1;
        req_valid   = 1'b0;
        req_wdata   = rnd_word();
        req_capture = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((sb.size() != 0 || resp_valid) && b < 5000) begin
            @(negedge clock);
            b++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: drives resp_ready, checks stability while held and pops on handshake.
    always @(negedge clock) begin
        if (reset) begin
            seen     = 1'b0;
            idle_chk = 1'b0;
            n_sh     = 0;
            n_cap    = 0;
            n_up     = 0;
        end else begin
            if ((int'(chain_capture) + int'(chain_shift) + int'(chain_update)) > 1) overlaps++;
            n_sh  += int'(chain_shift);
            n_cap += int'(chain_capture);
            n_up  += int'(chain_update);
            if (idle_chk) begin
                chk("req_ready_after_accept", req_ready, 1);
                chk("resp_valid_after_accept", resp_valid, 0);
                idle_chk = 1'b0;
            end
            if (resp_valid) begin
                if (!seen) begin
                    seen       = 1'b1;
                    rise       = cyc;
                    held_rdata = resp_rdata;
                    held_err   = resp_err;
                    unstable   = 0;
                end else if (resp_rdata !== held_rdata || resp_err !== held_err || req_ready) begin
                    unstable++;
                end
                if (hold_cnt > 0) begin
                    resp_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
                if (resp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got rdata %0h with no request outstanding", resp_rdata);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("rdata", resp_rdata, e.rdata);
                        chk("resp_err", resp_err, e.err);
                        chk("latency", rise - e.e0, CHAIN_LEN + (e.cap ? 2 : 1));
                        chk("shift_cycles", n_sh, CHAIN_LEN);
                        chk("capture_cycles", n_cap, e.cap);
                        chk("update_cycles", n_up, 1);
                        chk("chain_contents", chain_m, e.wdata);
                        chk("resp_stable", unstable, 0);
                    end
                    seen     = 1'b0;
                    idle_chk = 1'b1;
                    n_sh     = 0;
                    n_cap    = 0;
                    n_up     = 0;
                end
            end else begin
                resp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        // Reset values
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_strobes", {chain_capture, chain_shift, chain_update}, 0);
        chk("rst_chain_data", chain_data, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        @(negedge clock);
        reset = 1'b0;

        // Directed: capture then plain shift returning the previous contents
        send(word_t'(32'hDEADBEEF), 1'b1, word_t'(1));
        drain();
        send(rnd_word(), 1'b0, rnd_word());
        drain();

        // Held response
        hold_cnt = 10;
        send(rnd_word(), 1'b1, rnd_word());
        drain();

        // Reset in the middle of the shift phase
        send(rnd_word(), 1'b1, rnd_word());
        b = 0;
        @(negedge clock);
        while (!chain_shift && b < 500) begin
            @(negedge clock);
            b++;
        end
        chk("shift_start", chain_shift, 1);
        repeat (RST_AT - 1) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("midrst_strobes", {chain_capture, chain_shift, chain_update}, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_resp_valid", resp_valid, 0);
        sb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (CHAIN_LEN + 5) @(negedge clock);
        chk("midrst_no_resp", resp_valid, 0);
        send(rnd_word(), 1'b1, rnd_word());
        drain();

        // Capture signature with LSB clear
        send(rnd_word(), 1'b1, '0);
        drain();
        send(rnd_word(), 1'b1, word_t'(1));
        drain();

        // Random back-to-back traffic
        for (int i = 0; i < 1000; i++) begin
            send(rnd_word(), 1'($urandom_range(0, 1)), rnd_word());
        end
        drain();

        chk("strobe_overlap", overlaps, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_jtag_dr_scan_master

// File: doc/jtag_dr_scan_master.md
Name: jtag_dr_scan_master

Overview:
- Initiator side of the JTAG data-register chain interface: drives the capture, shift, update and serial-data strobes into one scan chain, and collects that chain's serial output.
- Converts a parallel request word (valid/ready) into a complete DR scan: optional capture, CHAIN_LEN shifts, one update.
- Returns the captured parallel word on a valid/ready response channel.
- Sits between a debug/test host engine and any capture/shift/update chain in the debug subsystem.

Parameters:
- CHAIN_LEN, 32, scan chain length in bits; legal range 1..1024.
- CNT_W, max(1,$clog2(CHAIN_LEN)), shift counter width; derived, not overridable.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  scan request valid.
- req_ready  out  1  high only in IDLE.
- req_wdata  in  CHAIN_LEN  word to shift in; bit k ends in chain stage k.
- req_capture  in  1  1 = issue capture before shifting.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accepted.
- resp_rdata  out  CHAIN_LEN  word shifted out; bit k = chain stage k before shifting.
- resp_err  out  1  capture-signature error (see Optional Feature).
- chain_capture  out  1  capture strobe to the chain.
- chain_shift  out  1  shift strobe to the chain.
- chain_update  out  1  update strobe to the chain.
- chain_data  out  1  serial data into the chain's far end.
- chain_out_data  in  1  serial data from the chain's stage 0.

Behaviour:
- Reset: asynchronous and active-high; FSM goes to IDLE. Reset values: req_ready=1, resp_valid=0, resp_err=0, all chain_* strobes=0, chain_data=0, resp_rdata=0.
- All outputs are registered. At most one of chain_capture/chain_shift/chain_update is high in any cycle.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, RESP.
- IDLE: req_ready=1. On req_valid at edge E0:
  - latch req_wdata into the tx shift register and clear the rx register;
  - go to CAPTURE if req_capture=1, else SHIFT.
- CAPTURE: chain_capture=1 for exactly one cycle, then SHIFT.
- SHIFT: chain_shift=1 for exactly CHAIN_LEN consecutive cycles.
  - chain_data = tx[0]; tx shifts right by 1 each cycle.
  - On each shift edge, chain_out_data enters rx at the MSB and rx shifts right. After CHAIN_LEN shifts, rx[k] = captured stage k.
  - Counter runs 0..CHAIN_LEN-1; on terminal count go to UPDATE. For CHAIN_LEN=1 this is a single shift cycle.
- UPDATE: chain_update=1 for one cycle; rx is copied to resp_rdata; then RESP.
- RESP: resp_valid=1 and resp_rdata/resp_err are held stable until resp_ready. The accepting edge returns to IDLE.
  - No new request is accepted in the same cycle; the earliest next accept is the following edge.
- Latency from the accepting edge E0:
  - resp_valid rises at edge E0+CHAIN_LEN+2 when req_capture=1;
  - resp_valid rises at edge E0+CHAIN_LEN+1 when req_capture=0.
- Request inputs are ignored outside IDLE; req_wdata only needs to be stable on the accepting edge.
- Reset mid-scan: strobes drop immediately. The chain contents and the response are discarded; no resp_valid is produced.
- resp_ready while resp_valid=0 has no effect.

Optional Feature:
- Macro: JTAG_SCAN_CAPTURE_CHECK_EN.
- Defined:
  - resp_err=1 on a response where req_capture=1 and captured bit 0 is not 1. This checks the IDCODE-style signature, whose LSB is always 1.
  - resp_err=0 for scans with req_capture=0.
  - A non-synthesis assertion fires if two chain strobes are ever high together.
- Not defined: resp_err is tied to 0 and no assertion is present. The port list is identical in both builds.

Decomposition:
- Package jtag_scan_pkg holds:
  - typedef enum scan_state_e {IDLE, CAPTURE, SHIFT, UPDATE, RESP};
  - localparam function cnt_width(len) returning max(1,$clog2(len)).
- No sub-module: FSM, counter and the two shift registers are a single module.

Test Plan:
- CHAIN_LEN=32, chain model loads 0x00000001 on capture. Request wdata=0xDEADBEEF, capture=1 -> 1 capture cycle, 32 shift cycles, 1 update cycle; rdata=0x00000001; chain holds 0xDEADBEEF; resp_valid at E0+34.
- Repeat with capture=0 -> no capture strobe; rdata=0xDEADBEEF (previous contents); chain now holds the new wdata; resp_valid at E0+33.
- Hold resp_ready=0 for 10 cycles -> resp_valid and rdata stable, req_ready=0. resp_ready=1 -> IDLE next cycle, req_ready=1.
- Assert reset at the 16th shift cycle -> all strobes 0 immediately, req_ready=1, no response. A new request completes normally.
- With JTAG_SCAN_CAPTURE_CHECK_EN, chain model capture value 0x00000000 -> resp_err=1. Without the macro -> resp_err=0.
- CHAIN_LEN=1, wdata=1, capture=1 with capture value 1 -> exactly one shift cycle, rdata=1, resp_valid at E0+3. Strobes never overlap across 1000 random back-to-back requests.
